// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and default widths for the I2C byte-level master
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // Transaction sequencer states, in bus order
  typedef enum logic [3:0] {
    ST_READY,
    ST_START,
    ST_ADDR,
    ST_SLV_ACK1,
    ST_WR,
    ST_RD,
    ST_SLV_ACK2,
    ST_MSTR_ACK,
    ST_STOP
  } state_t;

  // One user command as presented on the byte handshake
  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic [I2C_DATA_W-1:0] data;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_master_byte_fsm_if.sv
// rtl/i2c_master_byte_fsm_if.sv - stretcher strobe, user command handshake and SDA pins
interface i2c_master_byte_fsm_if #(
  parameter int ADDR_W = i2c_pkg::I2C_ADDR_W,
  parameter int DATA_W = i2c_pkg::I2C_DATA_W
) ();

  logic              data_clk;
  logic              ena;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] data_wr;
  logic              sda_in;
  logic              scl_not_ena;
  logic              sda_oe;
  logic              cmd_ack;
  logic              busy;
  logic [DATA_W-1:0] data_rd;
  logic              rd_valid;
  logic              ack_error;

  modport master (
    input  data_clk, ena, addr, rw, data_wr, sda_in,
    output scl_not_ena, sda_oe, cmd_ack, busy, data_rd, rd_valid, ack_error
  );

  modport slave (
    output data_clk, ena, addr, rw, data_wr, sda_in,
    input  scl_not_ena, sda_oe, cmd_ack, busy, data_rd, rd_valid, ack_error
  );

endinterface

// File: rtl/i2c_dclk_edge.sv
// rtl/i2c_dclk_edge.sv - turns the stretcher's data_clk into one-clk rise/fall strobes
module i2c_dclk_edge (
  input  logic clk,
  input  logic rst,
  input  logic data_clk_i,
  output logic rise_o,
  output logic fall_o
);

  logic dclk_q;

  // Remember last data_clk level; a frozen (stretched) data_clk yields no strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_q <= 1'b0;
    end else begin
      dclk_q <= data_clk_i;
    end
  end

  assign rise_o = data_clk_i & ~dclk_q;
  assign fall_o = ~data_clk_i & dclk_q;

endmodule

// File: rtl/i2c_master_byte_fsm.sv
// rtl/i2c_master_byte_fsm.sv - I2C master sequencer: START, addr+R/W, data bytes, ACK/NACK, STOP
module i2c_master_byte_fsm
  import i2c_pkg::*;
#(
  parameter int ADDR_W = I2C_ADDR_W,
  parameter int DATA_W = I2C_DATA_W
) (
  input logic                   clk,
  input logic                   rst,
  i2c_master_byte_fsm_if.master bus
);

  localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int AIDX_W = $clog2(ADDR_W + 1);
  localparam int DIDX_W = $clog2(DATA_W);

  logic rise;
  logic fall;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   addr_rw_q, addr_rw_d;
  logic [DATA_W-1:0] data_tx_q, data_tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] data_rd_q, data_rd_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sda_int_q, sda_int_d;
  logic              scl_ena_q, scl_ena_d;
  logic              busy_q, busy_d;
  logic              cmd_ack_q, cmd_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ack_error_q, ack_error_d;
  logic              cont_q, cont_d;

  logic [CNT_W-1:0]  cnt_m1;
  logic              same_cmd;

  i2c_dclk_edge u_dclk_edge (
    .clk       (clk),
    .rst       (rst),
    .data_clk_i(bus.data_clk),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  assign cnt_m1   = bit_cnt_q - 1'b1;
  assign same_cmd = ({bus.addr, bus.rw} == addr_rw_q);

  // State and datapath registers; reset leaves SCL and SDA released with no STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_READY;
      addr_rw_q   <= '0;
      data_tx_q   <= '0;
      rx_q        <= '0;
      data_rd_q   <= '0;
      bit_cnt_q   <= '0;
      sda_int_q   <= 1'b1;
      scl_ena_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ack_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      ack_error_q <= 1'b0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_rw_q   <= addr_rw_d;
      data_tx_q   <= data_tx_d;
      rx_q        <= rx_d;
      data_rd_q   <= data_rd_d;
      bit_cnt_q   <= bit_cnt_d;
      sda_int_q   <= sda_int_d;
      scl_ena_q   <= scl_ena_d;
      busy_q      <= busy_d;
      cmd_ack_q   <= cmd_ack_d;
      rd_valid_q  <= rd_valid_d;
      ack_error_q <= ack_error_d;
      cont_q      <= cont_d;
    end
  end

  // Next state: SDA changes on rise (SCL low), bus is sampled on fall (SCL high)
  always_comb begin
    state_d     = state_q;
    addr_rw_d   = addr_rw_q;
    data_tx_d   = data_tx_q;
    rx_d        = rx_q;
    data_rd_d   = data_rd_q;
    bit_cnt_d   = bit_cnt_q;
    sda_int_d   = sda_int_q;
    scl_ena_d   = scl_ena_q;
    busy_d      = busy_q;
    cmd_ack_d   = 1'b0;
    rd_valid_d  = 1'b0;
    ack_error_d = ack_error_q;
    cont_d      = cont_q;

    if (rise) begin
      case (state_q)
        ST_READY: begin
          if (bus.ena) begin
            addr_rw_d   = {bus.addr, bus.rw};
            data_tx_d   = bus.data_wr;
            cmd_ack_d   = 1'b1;
            busy_d      = 1'b1;
            ack_error_d = 1'b0;
            sda_int_d   = 1'b0;
            state_d     = ST_START;
          end
        end
        ST_START: begin
          sda_int_d = addr_rw_q[ADDR_W];
          bit_cnt_d = CNT_W'(ADDR_W);
          state_d   = ST_ADDR;
        end
        ST_ADDR: begin
          if (bit_cnt_q == '0) begin
            sda_int_d = 1'b1;
            state_d   = ST_SLV_ACK1;
          end else begin
            bit_cnt_d = cnt_m1;
            sda_int_d = addr_rw_q[cnt_m1[AIDX_W-1:0]];
          end
        end
        ST_SLV_ACK1: begin
          if (ack_error_q) begin
            sda_int_d = 1'b0;
            state_d   = ST_STOP;
          end else if (!addr_rw_q[0]) begin
            sda_int_d = data_tx_q[DATA_W-1];
            bit_cnt_d = CNT_W'(DATA_W - 1);
            state_d   = ST_WR;
          end else begin
            sda_int_d = 1'b1;
            bit_cnt_d = CNT_W'(DATA_W - 1);
            state_d   = ST_RD;
          end
        end
        ST_WR: begin
          if (bit_cnt_q == '0) begin
            sda_int_d = 1'b1;
            state_d   = ST_SLV_ACK2;
          end else begin
            bit_cnt_d = cnt_m1;
            sda_int_d = data_tx_q[cnt_m1[DIDX_W-1:0]];
          end
        end
        ST_RD: begin
          if (bit_cnt_q == '0) begin
            // ACK (low) only if the user still wants more bytes from the same slave
            cont_d    = bus.ena & same_cmd;
            sda_int_d = ~(bus.ena & same_cmd);
            state_d   = ST_MSTR_ACK;
          end else begin
            bit_cnt_d = cnt_m1;
          end
        end
        ST_SLV_ACK2: begin
          if (ack_error_q) begin
            // Drive SDA low first so the STOP state can release it as a real STOP
            sda_int_d = 1'b0;
            state_d   = ST_STOP;
          end else if (bus.ena && same_cmd) begin
            data_tx_d = bus.data_wr;
            cmd_ack_d = 1'b1;
            sda_int_d = bus.data_wr[DATA_W-1];
            bit_cnt_d = CNT_W'(DATA_W - 1);
            state_d   = ST_WR;
          end else begin
            sda_int_d = 1'b0;
            state_d   = ST_STOP;
          end
        end
        ST_MSTR_ACK: begin
          data_rd_d  = rx_q;
          rd_valid_d = 1'b1;
          if (cont_q) begin
            cmd_ack_d = 1'b1;
            sda_int_d = 1'b1;
            bit_cnt_d = CNT_W'(DATA_W - 1);
            state_d   = ST_RD;
          end else begin
            sda_int_d = 1'b0;
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          sda_int_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_READY;
        end
        default: begin
          state_d = ST_READY;
        end
      endcase
    end else if (fall) begin
      case (state_q)
        ST_START:    scl_ena_d   = 1'b1;
        ST_STOP:     scl_ena_d   = 1'b0;
        ST_SLV_ACK1: ack_error_d = ack_error_q | bus.sda_in;
        ST_SLV_ACK2: ack_error_d = ack_error_q | bus.sda_in;
        ST_RD:       rx_d        = {rx_q[DATA_W-2:0], bus.sda_in};
        default:     ;
      endcase
    end
  end

  assign bus.scl_not_ena = ~scl_ena_q;
  assign bus.sda_oe      = ~sda_int_q;
  assign bus.cmd_ack     = cmd_ack_q;
  assign bus.busy        = busy_q;
  assign bus.data_rd     = data_rd_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.ack_error   = ack_error_q;

endmodule
